// File: rtl/clockmaster_rst_pkg.sv
// Shared definitions for the clockmaster reset sequencer: FSM state encodings,
// default timing constants and a small constant helper for derived widths.
package clockmaster_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_DELAY    = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } rst_seq_state_t;

    localparam int DEFAULT_N_STAGES    = 4;
    localparam int DEFAULT_STAGE_DELAY = 16;
    localparam int DEFAULT_TIMEOUT     = 1024;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Shared settle/timeout counter for the reset sequencer. The owner picks the
// limit at run time; o_at_limit flags the edge on which the limit is reached.
module rst_seq_timer #(
    parameter int CNT_W = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] count;

    // Clear has priority over counting so a stage transition always restarts at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_at_limit = (count == i_limit);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one at a time in index order, waiting for each
// stage's ready plus a settle delay before releasing the next. Timeouts and
// loss of ready after full release drop every reset and latch a sticky fault.
module reset_sequencer
    import clockmaster_rst_pkg::*;
#(
    parameter  int N_STAGES    = DEFAULT_N_STAGES,
    parameter  int STAGE_DELAY = DEFAULT_STAGE_DELAY,
    parameter  int TIMEOUT     = DEFAULT_TIMEOUT,
    localparam int CNT_W       = $clog2(max_int(STAGE_DELAY, TIMEOUT) + 1),
    localparam int IDX_W       = max_int(1, $clog2(N_STAGES))
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_soft_rst,
    input  logic [N_STAGES-1:0] i_ready,
    output logic [N_STAGES-1:0] o_rst_n,
    output logic                o_done,
    output logic                o_fault,
    output logic [IDX_W-1:0]    o_fault_stage
);

    localparam logic [CNT_W-1:0] DELAY_LIMIT   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(N_STAGES - 1);

    rst_seq_state_t      state;
    rst_seq_state_t      state_next;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;

    logic                tmr_clr;
    logic                tmr_en;
    logic [CNT_W-1:0]    tmr_limit;
    logic                tmr_at_limit;

    logic [N_STAGES-1:0] rst_n_next;
    logic                done_next;
    logic                fault_next;
    logic [IDX_W-1:0]    fault_stage_next;

    function automatic logic [IDX_W-1:0] lowest_low(input logic [N_STAGES-1:0] rdy);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            if (!rdy[k]) begin
                res = IDX_W'(k);
            end
        end
        return res;
    endfunction

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (tmr_clr),
        .i_en       (tmr_en),
        .i_limit    (tmr_limit),
        .o_at_limit (tmr_at_limit)
    );

    // State, stage index and every output advance together so all outputs stay registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_HOLD;
            idx           <= '0;
            o_rst_n       <= '0;
            o_done        <= 1'b0;
            o_fault       <= 1'b0;
            o_fault_stage <= '0;
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            o_rst_n       <= rst_n_next;
            o_done        <= done_next;
            o_fault       <= fault_next;
            o_fault_stage <= fault_stage_next;
        end
    end

    // Sequencing decisions; soft reset overrides everything, and ready beats an expiring timeout.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_limit  = DELAY_LIMIT;
        if (i_soft_rst) begin
            state_next = ST_HOLD;
            idx_next   = '0;
            tmr_clr    = 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (tmr_at_limit) begin
                        state_next = ST_WAIT_RDY;
                        tmr_clr    = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    tmr_limit = TIMEOUT_LIMIT;
                    if (i_ready[idx]) begin
                        tmr_clr = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_DELAY;
                        end
                    end else if (tmr_at_limit) begin
                        state_next = ST_FAULT;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (tmr_at_limit) begin
                        state_next = ST_WAIT_RDY;
                        idx_next   = idx + IDX_W'(1);
                        tmr_clr    = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!(&i_ready)) begin
                        state_next = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_HOLD;
                    idx_next   = '0;
                    tmr_clr    = 1'b1;
                end
            endcase
        end
    end

    // Next output values: release one stage on each entry to WAIT_RDY, drop all on HOLD/FAULT.
    always_comb begin
        rst_n_next       = o_rst_n;
        done_next        = (state_next == ST_DONE);
        fault_next       = (state_next == ST_FAULT);
        fault_stage_next = o_fault_stage;
        if (state_next == ST_HOLD || state_next == ST_FAULT) begin
            rst_n_next = '0;
        end else if (state_next == ST_WAIT_RDY && state != ST_WAIT_RDY) begin
            rst_n_next[idx_next] = 1'b1;
        end
        if (state_next == ST_HOLD) begin
            fault_stage_next = '0;
        end else if (state_next == ST_FAULT && state != ST_FAULT) begin
            fault_stage_next = (state == ST_DONE) ? lowest_low(i_ready) : idx;
        end
    end

endmodule
